// File: rtl/blake_pkg.sv
// blake_pkg: shared constants, state type and word-slice helper for the BLAKE-512 state stage.
// Contents:
//    C0..C7 : first eight BLAKE-512 constants (64-bit)
//    state_t: controller states; FINAL exists only when BLAKE_FINALIZE_EN is defined
//    vidx(i): MSB position of word vi inside the 1024-bit state vector
package blake_pkg;

   localparam logic [63:0] C0 = 64'h243F6A8885A308D3;
   localparam logic [63:0] C1 = 64'h13198A2E03707344;
   localparam logic [63:0] C2 = 64'hA4093822299F31D0;
   localparam logic [63:0] C3 = 64'h082EFA98EC4E6C89;
   localparam logic [63:0] C4 = 64'h452821E638D01377;
   localparam logic [63:0] C5 = 64'hBE5466CF34E90C6C;
   localparam logic [63:0] C6 = 64'hC0AC29B7C97C50DD;
   localparam logic [63:0] C7 = 64'h3F84D5B5B5470917;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
`ifdef BLAKE_FINALIZE_EN
      FINAL,
`endif
      DONE
   } state_t;

   function automatic int vidx(input int i);
      return 1023 - 64 * i;
   endfunction

endpackage

// File: rtl/blake_init_vec.sv
// blake_init_vec: combinational build of the initial 1024-bit BLAKE-512 working state.
// Ports:
//    h : chain value h0..h7, h0 at [511:448]
//    s : salt s0..s3, s0 at [255:192]
//    t : bit counter, t0 = [63:0], t1 = [127:64]
//    v : initial state v0..v15, vi at [1023-64i -: 64]
module blake_init_vec
   import blake_pkg::*;
(
   input  logic [511:0]  h,
   input  logic [255:0]  s,
   input  logic [127:0]  t,
   output logic [1023:0] v
);

   assign v = {h,
               s[255:192] ^ C0, s[191:128] ^ C1, s[127:64] ^ C2, s[63:0] ^ C3,
               t[63:0] ^ C4, t[63:0] ^ C5, t[127:64] ^ C6, t[127:64] ^ C7};

endmodule

// File: rtl/blake_state_update.sv
// blake_state_update: BLAKE-512 working-state register, G write-back and round/step sequencing.
// Optional feature macro: BLAKE_FINALIZE_EN (adds FINAL state, h/s latches and h_out).
// Ports:
//    clk, rst_n       : clock, synchronous active-low reset
//    start            : begin compression (sampled in IDLE only)
//    h_in, s_in, t_in : chain value, salt, counter used to build the initial state
//    g_valid          : the eight G results are valid this cycle
//    a1..d1_out       : G unit 1 results; a2..d2_out: G unit 2 results
//    v_out            : working state, vi at [1023-64i -: 64]
//    counter_idx      : {round[3:0], step[1:0]} for the upstream operand mux
//    busy, done       : run in progress / one-cycle completion pulse
//    h_out            : finalized chain value (BLAKE_FINALIZE_EN only)
module blake_state_update
   import blake_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [511:0]  h_in,
   input  logic [255:0]  s_in,
   input  logic [127:0]  t_in,
   input  logic          g_valid,
   input  logic [63:0]   a1_out,
   input  logic [63:0]   b1_out,
   input  logic [63:0]   c1_out,
   input  logic [63:0]   d1_out,
   input  logic [63:0]   a2_out,
   input  logic [63:0]   b2_out,
   input  logic [63:0]   c2_out,
   input  logic [63:0]   d2_out,
   output logic [1023:0] v_out,
   output logic [5:0]    counter_idx,
   output logic          busy,
   output logic          done
`ifdef BLAKE_FINALIZE_EN
   ,
   output logic [511:0]  h_out
`endif
);

   state_t        state;
   logic [1023:0] v_init;
   logic [1023:0] v_nxt;
   logic [511:0]  gw;

   blake_init_vec u_init (.h(h_in), .s(s_in), .t(t_in), .v(v_init));

   assign gw = {a1_out, b1_out, c1_out, d1_out, a2_out, b2_out, c2_out, d2_out};

   // Word k (a=0..d=3) of unit u lands in row k; column is {step[0], u}, and on diagonal
   // steps (step[1]=1) row k is rotated left by k columns.
   function automatic logic [3:0] widx(input logic [1:0] step, input logic u, input logic [1:0] k);
      logic [1:0] col;
      col = {step[0], u};
      return {k, col + (step[1] ? k : 2'd0)};
   endfunction

   always_comb begin
      v_nxt = v_out;
      for (int u = 0; u < 2; u++)
         for (int k = 0; k < 4; k++)
            v_nxt[vidx(int'(widx(counter_idx[1:0], u[0], k[1:0]))) -: 64] = gw[511 - 64 * (4 * u + k) -: 64];
   end

`ifdef BLAKE_FINALIZE_EN
   logic [511:0] h_q;
   logic [255:0] s_q;
   logic [511:0] fin;

   always_comb begin
      fin = '0;
      for (int i = 0; i < 8; i++)
         fin[511 - 64 * i -: 64] = h_q[511 - 64 * i -: 64] ^ s_q[255 - 64 * (i % 4) -: 64]
                                 ^ v_out[vidx(i) -: 64] ^ v_out[vidx(i + 8) -: 64];
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         v_out       <= '0;
         counter_idx <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef BLAKE_FINALIZE_EN
         h_out       <= '0;
         h_q         <= '0;
         s_q         <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               v_out       <= v_init;
               counter_idx <= '0;
               busy        <= 1'b1;
               state       <= RUN;
`ifdef BLAKE_FINALIZE_EN
               h_q         <= h_in;
               s_q         <= s_in;
`endif
            end
            RUN: if (g_valid) begin
               v_out       <= v_nxt;
               counter_idx <= counter_idx + 6'd1;
`ifdef BLAKE_FINALIZE_EN
               if (counter_idx == 6'd63) state <= FINAL;
`else
               if (counter_idx == 6'd63) state <= DONE;
`endif
            end
`ifdef BLAKE_FINALIZE_EN
            FINAL: begin
               h_out <= fin;
               state <= DONE;
            end
`endif
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
